mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_pkg.sv | 12 +
 rtl/rr_arb2.sv | 16 +
 rtl/mem_arb.sv | 83 ++++++++
 tb/tb_mem_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, memory-port enable codes and burst FSM encoding for mem_arb.
package mem_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int DEPTH = 32;
  localparam logic [1:0] AM_ON = 2'b00;
  localparam logic [1:0] AM_OFF = 2'b11;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] k);
    return ADDR_W'((int'(a) + int'(k)) % DEPTH);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin (0 = host, 1 = compute); pointer moves only on a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       pick
);
  logic last;
  assign pick = req[1] & (~req[0] | ~last);
  assign gnt = (en && |req) ? (pick ? 2'b10 : 2'b01) : 2'b00;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last <= 1'b1;
    else if (|gnt) last <= pick;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: host/compute arbiter for a dual-port pair-read memory, with compute burst reads.
module mem_arb
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              c_burst,
  input  logic [3:0]        c_len,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic              c_busy,
  output logic [1:0]        R_am,
  output logic [1:0]        W_am,
  output logic [ADDR_W-1:0] R_addr,
  output logic [ADDR_W-1:0] W_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata1,
  input  logic [DATA_W-1:0] mem_rdata2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  state_t state;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] baddr, r_addr_q, ra, wa;
  logic [1:0] rreq, wreq, rg, wg;
  logic rp, wp, burst, haz, b_iss, r_on, w_on, h_rv, c_rv;
  assign burst = state == BURST;
  assign wreq = {c_req & c_we, h_req & h_we};
  assign rreq = burst ? 2'b00 : {c_req & ~c_we, h_req & ~h_we};
  rr_arb2 u_warb (.clk(clk), .rst(rst), .req(wreq), .en(rst), .gnt(wg), .pick(wp));
  rr_arb2 u_rarb (.clk(clk), .rst(rst), .req(rreq), .en(rst & ~haz), .gnt(rg), .pick(rp));
  assign w_on = |wg;
  assign wa = wp ? c_addr : h_addr;
  assign ra = burst ? baddr : (rp ? c_addr : h_addr);
  // a pair read touches ra and ra+1, so either may collide with the write
  assign haz = w_on && (ra == wa || addr_add(ra, ADDR_W'(1)) == wa);
  assign b_iss = rst && burst && !haz;
  assign r_on = |rg || b_iss;
  assign W_am = w_on ? AM_ON : AM_OFF;
  assign W_addr = w_on ? wa : '0;
  assign mem_wdata = w_on ? (wp ? c_wdata : h_wdata) : '0;
  assign R_am = r_on ? AM_ON : AM_OFF;
  assign R_addr = r_on ? ra : r_addr_q;
  assign h_gnt = wg[0] | rg[0];
  assign c_gnt = wg[1] | rg[1];
  assign h_rvalid = h_rv;
  assign c_rvalid = c_rv;
  assign c_busy = burst;
  assign rdata1 = (h_rv | c_rv) ? mem_rdata1 : '0;
  assign rdata2 = (h_rv | c_rv) ? mem_rdata2 : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      baddr <= '0;
      r_addr_q <= '0;
      h_rv <= 1'b0;
      c_rv <= 1'b0;
    end else begin
      h_rv <= rg[0];
      c_rv <= rg[1] | b_iss;
      if (r_on) r_addr_q <= ra;
      if (rg[1] && c_burst && c_len != 4'd0) begin
        state <= BURST;
        cnt <= c_len - 4'd1;
        baddr <= addr_add(ra, ADDR_W'(2));
      end else if (b_iss) begin
        if (cnt == 4'd0) state <= IDLE;
        cnt <= cnt - 4'd1;
        baddr <= addr_add(baddr, ADDR_W'(2));
      end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mem_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic h_req = 0, h_we = 0, c_req = 0, c_we = 0, c_burst = 0;
  logic [4:0] h_addr = 0, c_addr = 0;
  logic [63:0] h_wdata = 0, c_wdata = 0;
  logic [3:0] c_len = 0;
  logic [63:0] mem_rdata1 = 0, mem_rdata2 = 0;
  logic h_gnt, h_rvalid, c_gnt, c_rvalid, c_busy;
  logic [1:0] R_am, W_am;
  logic [4:0] R_addr, W_addr;
  logic [63:0] mem_wdata, rdata1, rdata2;
  logic [63:0] mem [32];
  logic init_mem = 1'b1;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_burst(c_burst), .c_len(c_len),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_busy(c_busy),
    .R_am(R_am), .W_am(W_am), .R_addr(R_addr), .W_addr(W_addr), .mem_wdata(mem_wdata),
    .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2), .rdata1(rdata1), .rdata2(rdata2)
  );

  function automatic logic [63:0] iv(input int i);
    return 64'h1111_0000_0000_0000 + 64'(i);
  endfunction

  // memory with registered pair-read outputs
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= iv(i);
    end else begin
      if (R_am == 2'b00) begin
        mem_rdata1 <= mem[R_addr];
        mem_rdata2 <= mem[5'(R_addr + 5'd1)];
      end
      if (W_am == 2'b00) mem[W_addr] <= mem_wdata;
    end
  end

  task automatic drive(input logic hq, input logic hw, input int ha, input logic [63:0] hd,
                       input logic cq, input logic cw, input logic cb, input int ca, input int cl,
                       input logic [63:0] cd);
    h_req = hq; h_we = hw; h_addr = 5'(ha); h_wdata = hd;
    c_req = cq; c_we = cw; c_burst = cb; c_addr = 5'(ca); c_len = 4'(cl); c_wdata = cd;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    init_mem = 1'b1;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 7, 64'hDEAD, 1, 0, 1, 9, 3, 64'hBEEF);
    #1;
    n_tests++;
    if ({h_gnt, c_gnt, h_rvalid, c_rvalid, c_busy, R_am, W_am} !== 9'b00000_11_11) begin
      n_fail++;
      $display("FAIL reset ctrl: got %b want 000001111", {h_gnt, c_gnt, h_rvalid, c_rvalid, c_busy, R_am, W_am});
    end
    n_tests++;
    if ({R_addr, W_addr, mem_wdata} !== 74'd0) begin
      n_fail++;
      $display("FAIL reset addr/data: got R=%0d W=%0d wd=%h want 0", R_addr, W_addr, mem_wdata);
    end
    apply_reset;
  endtask

  task automatic test_write_read;
    apply_reset;
    drive(1, 1, 3, 64'hA5A5, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++;
    if ({h_gnt, W_am, W_addr, mem_wdata} !== {1'b1, 2'b00, 5'd3, 64'hA5A5}) begin
      n_fail++;
      $display("FAIL wr grant: got g=%b am=%b a=%0d d=%h want 1 00 3 a5a5", h_gnt, W_am, W_addr, mem_wdata);
    end
    @(negedge clk);
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++;
    if ({h_gnt, R_am, R_addr, W_am} !== {1'b1, 2'b00, 5'd3, 2'b11}) begin
      n_fail++;
      $display("FAIL rd grant: got g=%b am=%b a=%0d wam=%b want 1 00 3 11", h_gnt, R_am, R_addr, W_am);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({h_rvalid, c_rvalid, rdata1, rdata2} !== {2'b10, 64'hA5A5, iv(4)}) begin
      n_fail++;
      $display("FAIL rd data: got v=%b%b d1=%h d2=%h want 10 a5a5 %h", h_rvalid, c_rvalid, rdata1, rdata2, iv(4));
    end
    @(negedge clk);
    n_tests++;
    if (h_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rvalid one-shot: got %b want 0", h_rvalid);
    end
  endtask

  task automatic test_alternate;
    apply_reset;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        n_tests++;
        if ({h_rvalid, c_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL alt rvalid %0d: got %b%b", i, h_rvalid, c_rvalid);
        end
      end
      drive(1, 0, 5, 0, 1, 0, 0, 10, 0, 0);
      #1;
      n_tests++;
      if ({h_gnt, c_gnt, R_addr} !== ((i % 2 == 0) ? {2'b10, 5'd5} : {2'b01, 5'd10})) begin
        n_fail++;
        $display("FAIL alt grant %0d: got h=%b c=%b a=%0d", i, h_gnt, c_gnt, R_addr);
      end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_hazard;
    apply_reset;
    drive(1, 1, 0, 64'hBEEF_0000, 1, 0, 0, 31, 0, 0);
    #1;
    n_tests++;
    if ({h_gnt, c_gnt, W_am, R_am} !== {2'b10, 2'b00, 2'b11}) begin
      n_fail++;
      $display("FAIL hazard hold: got h=%b c=%b wam=%b ram=%b want 1 0 00 11", h_gnt, c_gnt, W_am, R_am);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0, 31, 0, 0);
    #1;
    n_tests++;
    if ({c_gnt, R_am, R_addr} !== {1'b1, 2'b00, 5'd31}) begin
      n_fail++;
      $display("FAIL hazard retry: got c=%b am=%b a=%0d want 1 00 31", c_gnt, R_am, R_addr);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({c_rvalid, rdata1, rdata2} !== {1'b1, iv(31), 64'hBEEF_0000}) begin
      n_fail++;
      $display("FAIL hazard data: got v=%b d1=%h d2=%h want 1 %h beef0000", c_rvalid, rdata1, rdata2, iv(31));
    end
  endtask

  task automatic test_burst;
    int exp_a [4] = '{28, 30, 0, 2};
    apply_reset;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        n_tests++;
        if ({c_rvalid, h_rvalid} !== ((i < 5) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL burst rvalid %0d: got c=%b h=%b", i, c_rvalid, h_rvalid);
        end
        n_tests++;
        if ({rdata1, rdata2} !== ((i < 5) ? {iv(exp_a[i-1]), iv((exp_a[i-1] + 1) % 32)} : {iv(7), iv(8)})) begin
          n_fail++;
          $display("FAIL burst data %0d: got %h %h", i, rdata1, rdata2);
        end
      end
      if (i == 0) drive(0, 0, 0, 0, 1, 0, 1, 28, 3, 0);
      else if (i < 5) drive(1, 0, 7, 0, 1, 0, 1, 9, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (i < 4) begin
        n_tests++;
        if ({c_gnt, h_gnt, c_busy, R_am, R_addr} !== {i == 0, 1'b0, i != 0, 2'b00, 5'(exp_a[i])}) begin
          n_fail++;
          $display("FAIL burst issue %0d: got c=%b h=%b busy=%b am=%b a=%0d want a=%0d", i, c_gnt, h_gnt, c_busy, R_am, R_addr, exp_a[i]);
        end
      end else if (i == 4) begin
        n_tests++;
        if ({c_gnt, h_gnt, c_busy, R_addr} !== {3'b010, 5'd7}) begin
          n_fail++;
          $display("FAIL burst end: got c=%b h=%b busy=%b a=%0d want 0 1 0 7", c_gnt, h_gnt, c_busy, R_addr);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_burst;
    apply_reset;
    drive(0, 0, 0, 0, 1, 0, 1, 4, 5, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({c_gnt, c_rvalid, c_busy, R_am, R_addr} !== {3'b000, 2'b11, 5'd0}) begin
      n_fail++;
      $display("FAIL mid-burst reset: got g=%b v=%b busy=%b am=%b a=%0d want 000 11 0", c_gnt, c_rvalid, c_busy, R_am, R_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({c_rvalid, c_busy, R_am} !== 4'b0011) begin
        n_fail++;
        $display("FAIL post-reset idle %0d: got v=%b busy=%b am=%b want 0 0 11", i, c_rvalid, c_busy, R_am);
      end
    end
  endtask

  task automatic test_random;
    int rlast, wlast, ra, wa, rwin, wwin, mra;
    bit fb, eb, eh, ec, ehr, ecr, hw, hr, cw, cr;
    logic [63:0] e1, e2;
    logic [63:0] sh [32];
    int bq [$];
    apply_reset;
    rlast = 1; wlast = 1; mra = 0; ehr = 0; ecr = 0; e1 = 0; e2 = 0;
    for (int i = 0; i < 32; i++) sh[i] = iv(i);
    for (int n = 0; n < 400; n++) begin
      n_tests++;
      if ({h_rvalid, c_rvalid} !== {ehr, ecr}) begin
        n_fail++;
        $display("FAIL rand rvalid @%0d: got %b%b want %b%b", n, h_rvalid, c_rvalid, ehr, ecr);
      end
      if (ehr || ecr) begin
        n_tests++;
        if ({rdata1, rdata2} !== {e1, e2}) begin
          n_fail++;
          $display("FAIL rand rdata @%0d: got %h %h want %h %h", n, rdata1, rdata2, e1, e2);
        end
      end
      drive($urandom_range(0, 3) != 0, 1'($urandom), ($urandom_range(0, 1) != 0) ? $urandom_range(0, 5) : $urandom_range(28, 31),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 5) : $urandom_range(28, 31), $urandom_range(0, 4), {$urandom, $urandom});
      #1;
      hw = h_req && h_we; hr = h_req && !h_we; cw = c_req && c_we; cr = c_req && !c_we;
      eb = bq.size() != 0;
      fb = eb;
      wwin = (hw && cw) ? 1 - wlast : hw ? 0 : cw ? 1 : -1;
      rwin = eb ? 1 : (hr && cr) ? 1 - rlast : hr ? 0 : cr ? 1 : -1;
      ra = eb ? bq[0] : (rwin == 1) ? int'(c_addr) : int'(h_addr);
      wa = (wwin == 1) ? int'(c_addr) : int'(h_addr);
      if (rwin >= 0 && wwin >= 0 && (ra == wa || (ra + 1) % 32 == wa)) rwin = -1;
      eh = wwin == 0 || (rwin == 0 && !fb);
      ec = wwin == 1 || (rwin == 1 && !fb);
      n_tests++;
      if ({h_gnt, c_gnt, c_busy, R_am, W_am} !== {eh, ec, eb, (rwin >= 0) ? 2'b00 : 2'b11, (wwin >= 0) ? 2'b00 : 2'b11}) begin
        n_fail++;
        $display("FAIL rand ctrl @%0d: got h=%b c=%b busy=%b ram=%b wam=%b want %b %b %b rwin=%0d wwin=%0d",
                 n, h_gnt, c_gnt, c_busy, R_am, W_am, eh, ec, eb, rwin, wwin);
      end
      n_tests++;
      if (R_addr !== 5'((rwin >= 0) ? ra : mra)) begin
        n_fail++;
        $display("FAIL rand R_addr @%0d: got %0d want %0d", n, R_addr, (rwin >= 0) ? ra : mra);
      end
      if (wwin >= 0) begin
        n_tests++;
        if ({W_addr, mem_wdata} !== {5'(wa), (wwin == 1) ? c_wdata : h_wdata}) begin
          n_fail++;
          $display("FAIL rand write @%0d: got a=%0d d=%h want a=%0d", n, W_addr, mem_wdata, wa);
        end
      end
      ehr = rwin == 0;
      ecr = rwin == 1;
      if (rwin >= 0) begin
        e1 = sh[ra];
        e2 = sh[(ra + 1) % 32];
        mra = ra;
        if (fb) void'(bq.pop_front());
        else begin
          rlast = rwin;
          if (rwin == 1 && c_burst)
            for (int k = 1; k <= int'(c_len); k++) bq.push_back((ra + 2 * k) % 32);
        end
      end
      if (wwin >= 0) begin
        sh[wa] = (wwin == 1) ? c_wdata : h_wdata;
        wlast = wwin;
      end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_alternate;
    test_hazard;
    test_burst;
    test_reset_mid_burst;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
